// File: rtl/pipe_stage_skid.sv
// Purpose: two-entry pipeline stage (output register + skid register) carrying a control and a data bundle, with flush and a bubble counter.
// Latency: 1 cycle from an empty stage to the output. Sustains 1 entry/cycle while out_ready is held high.
// Backpressure: in_ready is registered and equals NOT skid_valid. The skid entry absorbs the cycle in which in_ready was still 1.
//
// Ports:
//   clk, reset                     sole clock and synchronous active-high reset
//   in_valid/in_ready/in_ctrl/in_data     upstream handshake and bundles
//   out_valid/out_ready/out_ctrl/out_data downstream handshake and bundles
//   flush                          kills held entries and the entry offered this cycle
//   occupancy                      held entries (0..2)
//   bubble_cnt                     saturating count of bubbles consumed downstream
module pipe_stage_skid #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 149,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_out_vld;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [DATA_W-1:0] r_out_data;
    logic              r_skid_vld;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_rdy;
    logic [1:0]        r_occ;
    logic [CNT_W-1:0]  r_bub_cnt;

    logic              w_xfer_in;
    logic              w_out_load;
    logic              w_bub_inc;
    logic              w_out_vld_n;
    logic [CTRL_W-1:0] w_out_ctrl_n;
    logic [DATA_W-1:0] w_out_data_n;
    logic              w_skid_vld_n;
    logic [CTRL_W-1:0] w_skid_ctrl_n;
    logic [DATA_W-1:0] w_skid_data_n;

    assign w_xfer_in  = in_valid & r_in_rdy & ~flush;
    assign w_out_load = ~r_out_vld | out_ready;
    // A bubble is a cycle where downstream is ready but nothing is offered.
    assign w_bub_inc  = ~r_out_vld & out_ready & (r_bub_cnt != {CNT_W{1'b1}});

    always_comb begin
        w_out_vld_n   = r_out_vld;
        w_out_ctrl_n  = r_out_ctrl;
        w_out_data_n  = r_out_data;
        w_skid_vld_n  = r_skid_vld;
        w_skid_ctrl_n = r_skid_ctrl;
        w_skid_data_n = r_skid_data;
        if (flush) begin
            // out_data and the skid payload are kept. Only the valids and the control are killed.
            w_out_vld_n  = 1'b0;
            w_out_ctrl_n = '0;
            w_skid_vld_n = 1'b0;
        end else if (w_out_load) begin
            if (r_skid_vld) begin
                // The skid entry is older than anything on the input.
                // in_ready was 0 this cycle, so no input can be accepted alongside it.
                w_out_vld_n  = 1'b1;
                w_out_ctrl_n = r_skid_ctrl;
                w_out_data_n = r_skid_data;
                w_skid_vld_n = 1'b0;
            end else if (w_xfer_in) begin
                w_out_vld_n  = 1'b1;
                w_out_ctrl_n = in_ctrl;
                w_out_data_n = in_data;
            end else begin
                // Bubble: zero the control so it has no side effects. Data holds its last value.
                w_out_vld_n  = 1'b0;
                w_out_ctrl_n = '0;
            end
        end else if (w_xfer_in) begin
            w_skid_vld_n  = 1'b1;
            w_skid_ctrl_n = in_ctrl;
            w_skid_data_n = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld   <= 1'b0;
            r_out_ctrl  <= '0;
            r_out_data  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_in_rdy    <= 1'b1;
            r_occ       <= 2'd0;
            r_bub_cnt   <= '0;
        end else begin
            r_out_vld   <= w_out_vld_n;
            r_out_ctrl  <= w_out_ctrl_n;
            r_out_data  <= w_out_data_n;
            r_skid_vld  <= w_skid_vld_n;
            r_skid_ctrl <= w_skid_ctrl_n;
            r_skid_data <= w_skid_data_n;
            r_in_rdy    <= ~w_skid_vld_n;
            r_occ       <= {1'b0, w_out_vld_n} + {1'b0, w_skid_vld_n};
            if (w_bub_inc) begin
                r_bub_cnt <= r_bub_cnt + 1'b1;
            end
        end
    end

    assign in_ready   = r_in_rdy;
    assign out_valid  = r_out_vld;
    assign out_ctrl   = r_out_ctrl;
    assign out_data   = r_out_data;
    assign occupancy  = r_occ;
    assign bubble_cnt = r_bub_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    localparam int CTRL_W = 9;
    localparam int DATA_W = 149;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [CTRL_W+DATA_W-1:0] sb_q[$];

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: inputs change at posedge+1, so they are stable at the negedge before the edge that samples them.
    always @(negedge clk) begin
        logic [CTRL_W+DATA_W-1:0] exp_e;
        if (reset) begin
            sb_q.delete();
        end else begin
            n_tests++;
            if (int'(occupancy) != sb_q.size()) begin
                n_fail++;
                $display("FAIL sb_occupancy: got %0d want %0d", occupancy, sb_q.size());
            end
            n_tests++;
            if (in_ready !== (sb_q.size() < 2)) begin
                n_fail++;
                $display("FAIL sb_in_ready: got %b want %b", in_ready, sb_q.size() < 2);
            end
            if (!out_valid) begin
                n_tests++;
                if (out_ctrl !== '0) begin
                    n_fail++;
                    $display("FAIL sb_bubble_ctrl: got %h want 0", out_ctrl);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                n_out++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_out: got ctrl %h with no entry expected", out_ctrl);
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({out_ctrl, out_data} !== exp_e) begin
                        n_fail++;
                        $display("FAIL sb_order: got %h_%h want %h", out_ctrl, out_data, exp_e);
                    end
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[DATA_W-1:0];
    endfunction

    task automatic check_reset_values(input string nm);
        n_tests++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0
            || in_ready !== 1'b1 || bubble_cnt !== '0) begin
            n_fail++;
            $display("FAIL %s: got v=%b c=%h d0=%b occ=%0d rdy=%b bub=%0d want v=0 c=0 d0=1 occ=0 rdy=1 bub=0",
                     nm, out_valid, out_ctrl, out_data == '0, occupancy, in_ready, bubble_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick(); tick();
        check_reset_values("reset_state");
        flush = 1'b0; in_valid = 1'b0; reset = 1'b0;
    endtask

    task automatic test_bubble_sat();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_tests++;
            if (int'(bubble_cnt) != ((i > 15) ? 15 : i)) begin
                n_fail++;
                $display("FAIL bubble_cnt cycle %0d: got %0d want %0d", i, bubble_cnt, (i > 15) ? 15 : i);
            end
        end
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] a;
        a = rnd_data();
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 9'h1A5; in_data = a;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_ctrl !== 9'h1A5 || out_data !== a || occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL single_latency: got v=%b c=%h occ=%0d want v=1 c=1a5 occ=1", out_valid, out_ctrl, occupancy);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== a) begin
            n_fail++;
            $display("FAIL single_drain: got v=%b c=%h want v=0 c=0 data held", out_valid, out_ctrl);
        end
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] da, db, dc;
        da = rnd_data(); db = rnd_data(); dc = rnd_data();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 9'h011; in_data = da; tick();
        in_ctrl = 9'h022; in_data = db; tick();
        n_tests++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready);
        end
        in_ctrl = 9'h033; in_data = dc; tick(); tick();
        n_tests++;
        if (occupancy !== 2'd2 || out_ctrl !== 9'h011 || out_data !== da) begin
            n_fail++;
            $display("FAIL fill_hold: got occ=%0d c=%h want occ=2 c=011", occupancy, out_ctrl);
        end
        out_ready = 1'b1; tick();
        n_tests++;
        if (out_ctrl !== 9'h022 || out_data !== db || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_skid_first: got c=%h occ=%0d rdy=%b want c=022 occ=1 rdy=1", out_ctrl, occupancy, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_ctrl !== 9'h033 || out_data !== dc) begin
            n_fail++;
            $display("FAIL fill_third: got v=%b c=%h want v=1 c=033", out_valid, out_ctrl);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_ctrl = 9'h044; in_data = rnd_data(); tick();
        in_ctrl = 9'h055; in_data = rnd_data(); tick();
        flush = 1'b1; out_ready = 1'b1; in_ctrl = 9'h066; in_data = rnd_data();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b c=%h occ=%0d rdy=%b want v=0 c=0 occ=0 rdy=1",
                     out_valid, out_ctrl, occupancy, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_discard: got out_valid=%b ctrl=%h want 0", out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_ctrl = CTRL_W'(9'h100 + i); in_data = rnd_data();
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_ctrl !== CTRL_W'(9'h100 + i)) begin
                n_fail++;
                $display("FAIL b2b beat %0d: got v=%b rdy=%b c=%h want v=1 rdy=1 c=%h",
                         i, out_valid, in_ready, out_ctrl, CTRL_W'(9'h100 + i));
            end
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_stream();
        int sent = 0;
        int cyc = 0;
        int out0;
        out0 = n_out;
        in_valid = 1'b0;
        while ((sent < 100 || occupancy != 0) && cyc < 3000) begin
            if (!in_valid && sent < 100) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_ctrl = CTRL_W'($urandom); in_data = rnd_data();
            end
            out_ready = (sent >= 100) || ($urandom_range(0, 2) != 0);
            @(posedge clk);
            if (in_valid && in_ready) sent++;
            #1;
            if (in_valid && in_ready == 1'b0) begin
                // Hold the offer until accepted.
            end else if (in_valid && sent > 0) begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (cyc >= 3000 || n_out - out0 != 100 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream: got %0d outputs in %0d cycles (%0d pending) want 100", n_out - out0, cyc, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_ctrl = 9'h077; in_data = rnd_data(); tick();
        in_ctrl = 9'h088; in_data = rnd_data(); tick();
        n_tests++;
        if (occupancy !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_mid_prefill: got occ=%0d want 2", occupancy);
        end
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
        tick();
        check_reset_values("reset_mid");
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_bubble_sat();
        test_single();
        test_fill();
        test_flush();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
